// File: rtl/tff_bank_arbiter.sv
// Shared bank of toggle flip-flops driven by two round-robin requesters and
// a counting controller. In IDLE the requesters apply toggle masks one per
// granted cycle; a counting run turns the bank into a synchronous
// up-counter for a programmed number of increments.
module tff_bank_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] mask0,
  input  logic             req1,
  input  logic [WIDTH-1:0] mask1,
  input  logic             cnt_start,
  input  logic [3:0]       cnt_len,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_remaining;
  logic [3:0]       w_remaining_next;
  logic             r_done;
  logic             w_done_next;
  // 1 = requester 1 wins the next contested cycle; reset favours requester 0
  logic             r_prio1;
  logic             w_prio1_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_inc_t;
  logic             w_gnt0;
  logic             w_gnt1;

  // Increment toggle vector: bit i toggles when all lower bits are ones
  assign w_inc_t[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_inc
      assign w_inc_t[gi] = &r_q[gi-1:0];
    end
  endgenerate

  // Next-state, toggle vector and grant decode
  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_done_next      = 1'b0;
    w_prio1_next     = r_prio1;
    w_t              = '0;
    w_gnt0           = 1'b0;
    w_gnt1           = 1'b0;
    case (r_state)
      IDLE: begin
        if (cnt_start) begin
          // Counting request beats any pending toggle request
          w_remaining_next = cnt_len;
          if (cnt_len != 4'd0) begin
            w_state_next = COUNT;
          end else begin
            w_done_next = 1'b1;
          end
        end else begin
          if (req0 && req1) begin
            w_gnt1 = r_prio1;
            w_gnt0 = ~r_prio1;
          end else begin
            w_gnt0 = req0;
            w_gnt1 = req1;
          end
          // Pointer moves only when a mask is actually applied
          if (w_gnt0) begin
            w_t          = mask0;
            w_prio1_next = 1'b1;
          end else if (w_gnt1) begin
            w_t          = mask1;
            w_prio1_next = 1'b0;
          end
        end
      end
      COUNT: begin
        w_t              = w_inc_t;
        w_remaining_next = r_remaining - 4'd1;
        if (r_remaining <= 4'd1) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State, counter, pointer and T flip-flop bank registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_remaining <= 4'd0;
      r_done      <= 1'b0;
      r_prio1     <= 1'b0;
      r_q         <= '0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
      r_done      <= w_done_next;
      r_prio1     <= w_prio1_next;
      r_q         <= r_q ^ w_t;
    end
  end

  // Grants are held low during reset without waiting for a clock
  assign gnt0 = w_gnt0 & ~reset;
  assign gnt1 = w_gnt1 & ~reset;
  assign busy = (r_state == COUNT);
  assign done = r_done;
  assign q    = r_q;

endmodule

// File: doc/tff_bank_arbiter.md
TFF_BANK_ARBITER -- requirements
Module: tff_bank_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of toggle flip-flops in the shared bank.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req0, input, 1 bit: requester 0 asks for one toggle operation.
REQ-005 The block SHALL have port mask0, input, WIDTH bits: requester 0 toggle mask, where bit i=1 toggles q[i].
REQ-006 The block SHALL have ports req1, input, 1 bit, and mask1, input, WIDTH bits, with the same meaning for requester 1.
REQ-007 The block SHALL have port cnt_start, input, 1 bit: request a counting run.
REQ-008 The block SHALL have port cnt_len, input, 4 bits: number of increments in the run.
REQ-009 The block SHALL have ports gnt0 and gnt1, output, 1 bit each: combinational grants.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a counting run is active.
REQ-011 The block SHALL have port done, output, 1 bit: registered one-cycle pulse at the end of a run.
REQ-012 The block SHALL have port q, output, WIDTH bits: the toggle-flip-flop bank state.

Function
REQ-013 The bank SHALL obey the T flip-flop rule on every edge: q[i] <= q[i] ^ T[i], where T is the toggle vector chosen by the controller.
REQ-014 The FSM SHALL have two states: IDLE and COUNT; busy SHALL be 1 exactly when the state is COUNT.
REQ-015 In IDLE with cnt_start=1, the block SHALL load remaining <= cnt_len and enter COUNT if cnt_len != 0, with T=0 and both grants 0 in that cycle.
REQ-016 In IDLE with cnt_start=1 and cnt_len=0, the block SHALL stay in IDLE, leave q unchanged, and pulse done in the next cycle.
REQ-017 In IDLE with cnt_start=0, the block SHALL assert at most one grant combinationally in the same cycle as the request.
REQ-018 In IDLE with cnt_start=0, a transfer SHALL occur at the edge where reqN=1 and gntN=1, with T=maskN, so one mask is applied per granted cycle.
REQ-019 With a single request active, its grant SHALL be 1.
REQ-020 With both requests active, the block SHALL grant the requester not granted most recently (round-robin pointer).
REQ-021 The round-robin pointer SHALL update only on a transfer.
REQ-022 A requester holding req high SHALL receive further grants per the round-robin rule; the block SHALL NOT impose hold-off.
REQ-023 In COUNT, the block SHALL set T[0]=1 and T[i]=&q[i-1:0], giving a synchronous increment that wraps from all-ones to 0.
REQ-024 In COUNT, remaining SHALL decrement on each increment edge.
REQ-025 In COUNT, the edge with remaining=1 SHALL perform the final increment, return the FSM to IDLE, and set done=1 for exactly the following cycle.
REQ-026 In COUNT, gnt0 and gnt1 SHALL be 0 and cnt_start SHALL be ignored.
REQ-027 When cnt_start and requests are both present in IDLE, cnt_start SHALL win and no grant SHALL be issued.
REQ-028 done SHALL be 0 in every cycle other than those defined in REQ-016 and REQ-025.

Reset
REQ-029 While reset=1, the block SHALL force immediately, without waiting for clk: q=0, state=IDLE, remaining=0, done=0, busy=0, gnt0=gnt1=0, and pointer favouring req0.
REQ-030 A reset asserted mid-run SHALL abort the run with no done pulse.
REQ-031 After reset deasserts, the first rising edge SHALL operate normally from IDLE.

Verification (WIDTH=4)
REQ-032 The bench SHALL cover: reset, then req0=1, mask0=0101 for one cycle -> gnt0=1 in that cycle, gnt1=0, q=0101 after the edge.
REQ-033 The bench SHALL cover: from q=0000, req0 and req1 held 4 cycles with mask0=0001 and mask1=0010 -> grants 0,1,0,1 and q=0001, 0011, 0010, 0000.
REQ-034 The bench SHALL cover: from q=1110, cnt_start=1 with cnt_len=3, plus req1=1 throughout -> busy for 3 cycles, q=1111, 0000, 0001, done for 1 cycle after, and gnt1=0 during busy.
REQ-035 The bench SHALL cover: cnt_start=1 with cnt_len=0 -> done=1 in the next cycle only, busy=0 throughout, q unchanged.
REQ-036 The bench SHALL cover: reset pulsed between clock edges in the 2nd cycle of a cnt_len=5 run -> q=0000 and busy=0 immediately, no done pulse; then req1 alone -> gnt1=1.
REQ-037 The bench SHALL cover: cnt_start=1 with cnt_len=2 and req0=1 in the same IDLE cycle -> gnt0=0, q unchanged at that edge, then the run proceeds.
